// File: rtl/risc16_prog_loader.sv
// ---------------------------------------------------------------------------
// risc16_prog_loader
//   Loads a RISC-16 program from a framed byte stream into the instruction RAM
//   write port. Once the frame checks good, the loader pulses the CPU reset for
//   one cycle and then holds execute enable high until the next frame starts.
//
//   Frame: SYNC_BYTE, N, N x {hi, lo}, CSUM   (CSUM = XOR of N and all data bytes)
//
// Ports
//   clk_i, rst_i        clock, synchronous active-high reset
//   s_data_i/s_valid_i  incoming byte stream
//   s_ready_o           byte accepted when s_valid_i & s_ready_o (low only
//                       during the one-cycle CPU reset pulse)
//   wr_en_o/wr_addr_o/wr_data_o  instruction RAM write port (one-cycle strobe)
//   cpu_rst_o           one-cycle reset pulse to the core after a good frame
//   execute_en_o        core execute enable, high from the cycle after cpu_rst_o
//   busy_o              a frame is being received (count, data or checksum)
//   error_o             sticky frame error, cleared by the next SYNC_BYTE
// ---------------------------------------------------------------------------
module risc16_prog_loader #(
  parameter int          ADDR_W    = 4,
  parameter logic [7:0]  SYNC_BYTE = 8'hA5
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic [7:0]        s_data_i,
  input  logic              s_valid_i,
  output logic              s_ready_o,
  output logic              wr_en_o,
  output logic [ADDR_W-1:0] wr_addr_o,
  output logic [15:0]       wr_data_o,
  output logic              cpu_rst_o,
  output logic              execute_en_o,
  output logic              busy_o,
  output logic              error_o
);

  localparam int         DEPTH   = 2**ADDR_W;
  // Word count limit in a width wide enough to hold DEPTH itself.
  localparam logic [8:0] DEPTH_N = 9'(DEPTH);

  typedef enum logic [2:0] {
    S_IDLE,
    S_COUNT,
    S_DATA_HI,
    S_DATA_LO,
    S_CSUM,
    S_RUN_RST,
    S_RUN,
    S_ERR
  } state_t;

  typedef struct packed {
    logic [ADDR_W-1:0] addr;
    logic [15:0]       data;
  } wr_req_t;

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [ADDR_W-1:0] last_q, last_d;   // address of word N (N-1)
  logic [7:0]        acc_q, acc_d;     // running XOR of N and data bytes
  logic [7:0]        hi_q, hi_d;
  wr_req_t           wr_req_q, wr_req_d;
  logic              wr_fire;
  logic              wr_vld_q;

  logic              ready_q, cpu_rst_q, exec_q, busy_q, err_q;

  logic              accept;
  logic              is_sync;
  logic              n_bad;

  assign accept  = s_valid_i & ready_q;
  assign is_sync = (s_data_i == SYNC_BYTE);
  assign n_bad   = (s_data_i == 8'd0) || ({1'b0, s_data_i} > DEPTH_N);

  // -------------------------------------------------------------------------
  // Next-state / datapath
  // -------------------------------------------------------------------------
  always_comb begin
    state_d  = state_q;
    addr_d   = addr_q;
    last_d   = last_q;
    acc_d    = acc_q;
    hi_d     = hi_q;
    wr_req_d = wr_req_q;
    wr_fire  = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (accept && is_sync) state_d = S_COUNT;
      end

      S_COUNT: begin
        if (accept) begin
          acc_d   = s_data_i;
          addr_d  = '0;
          // Only meaningful when N is in range; N-1 fits in ADDR_W bits then.
          last_d  = ADDR_W'(s_data_i - 8'd1);
          state_d = n_bad ? S_ERR : S_DATA_HI;
        end
      end

      S_DATA_HI: begin
        if (accept) begin
          hi_d    = s_data_i;
          acc_d   = acc_q ^ s_data_i;
          state_d = S_DATA_LO;
        end
      end

      S_DATA_LO: begin
        if (accept) begin
          acc_d         = acc_q ^ s_data_i;
          wr_fire       = 1'b1;
          wr_req_d.addr = addr_q;
          wr_req_d.data = {hi_q, s_data_i};
          // With N == DEPTH the counter wraps to 0 here, but we leave for
          // CSUM on the same edge, so no wrapped write can follow.
          addr_d        = addr_q + 1'b1;
          state_d       = (addr_q == last_q) ? S_CSUM : S_DATA_HI;
        end
      end

      S_CSUM: begin
        if (accept) state_d = (s_data_i == acc_q) ? S_RUN_RST : S_ERR;
      end

      // Ready is low here, so no byte can be consumed during the pulse.
      S_RUN_RST: state_d = S_RUN;

      S_RUN, S_ERR: begin
        if (accept && is_sync) state_d = S_COUNT;
      end

      default: state_d = S_IDLE;
    endcase
  end

  // -------------------------------------------------------------------------
  // State, datapath and registered outputs. Outputs are decoded from state_d
  // so they are flops that track the state register cycle for cycle.
  // -------------------------------------------------------------------------
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q   <= S_IDLE;
      addr_q    <= '0;
      last_q    <= '0;
      acc_q     <= '0;
      hi_q      <= '0;
      wr_req_q  <= '0;
      wr_vld_q  <= 1'b0;
      ready_q   <= 1'b1;
      cpu_rst_q <= 1'b0;
      exec_q    <= 1'b0;
      busy_q    <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      addr_q    <= addr_d;
      last_q    <= last_d;
      acc_q     <= acc_d;
      hi_q      <= hi_d;
      wr_vld_q  <= wr_fire;
      if (wr_fire) wr_req_q <= wr_req_d;
      ready_q   <= (state_d != S_RUN_RST);
      cpu_rst_q <= (state_d == S_RUN_RST);
      exec_q    <= (state_d == S_RUN);
      busy_q    <= (state_d == S_COUNT)   || (state_d == S_DATA_HI) ||
                   (state_d == S_DATA_LO) || (state_d == S_CSUM);
      err_q     <= (state_d == S_ERR);
    end
  end

  assign s_ready_o    = ready_q;
  assign wr_en_o      = wr_vld_q;
  assign wr_addr_o    = wr_req_q.addr;
  assign wr_data_o    = wr_req_q.data;
  assign cpu_rst_o    = cpu_rst_q;
  assign execute_en_o = exec_q;
  assign busy_o       = busy_q;
  assign error_o      = err_q;

endmodule
